// File: rtl/dcache_miss_ctrl.sv
// dcache_miss_ctrl: per-access control FSM for a 2-way, 32-set write-back D-cache.
//
// Takes the tag-compare result and the LRU victim select. Drives the LRU update
// strobes, and runs the dirty-victim writeback and the line refill on a word-beat
// memory port.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   req_*_i, busy_o,
//   resp_done_o               CPU-side request and completion
//   hit*/tag*/dirty*_i        tag-array compare results for the set at lru_index_o
//   way_sel_i                 LRU victim select
//   lru_*_o                   LRU index, hit way and update/change strobes
//   mem_*                     word-beat memory interface
//   beat_o, fill_we_o,
//   tag_we_o, dirty_set_o,
//   acc_way_o                 data/tag array write controls
//
// Optional build macro DCACHE_PERF_CNT_EN adds hit_cnt_o / miss_cnt_o counters.
module dcache_miss_ctrl #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned INDEX_W    = 5,
  parameter int unsigned OFFSET_W   = 4,
  parameter int unsigned TAG_W      = 23,
  localparam int unsigned BeatW     = $clog2(LINE_WORDS)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  input  logic               req_we_i,
  input  logic [31:0]        req_addr_i,
  output logic               busy_o,
  output logic               resp_done_o,
  input  logic               hit1_i,
  input  logic               hit2_i,
  input  logic [TAG_W-1:0]   tag1_i,
  input  logic [TAG_W-1:0]   tag2_i,
  input  logic               dirty1_i,
  input  logic               dirty2_i,
  input  logic               way_sel_i,
  output logic [INDEX_W-1:0] lru_index_o,
  output logic               lru_hit1_o,
  output logic               lru_hit2_o,
  output logic               lru_update_o,
  output logic               lru_change_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [31:0]        mem_addr_o,
  input  logic               mem_ack_i,
  output logic [BeatW-1:0]   beat_o,
  output logic               fill_we_o,
  output logic               tag_we_o,
  output logic               dirty_set_o,
  output logic               acc_way_o
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]        hit_cnt_o,
  output logic [31:0]        miss_cnt_o
`endif
);

  typedef enum logic [2:0] {StIdle, StLookup, StWb, StRefill, StDone} state_e;

  state_e             state_q, state_d;
  logic [BeatW-1:0]   beat_q, beat_d;
  logic               victim_q, victim_d;
  logic [TAG_W-1:0]   req_tag_q;
  logic [INDEX_W-1:0] req_idx_q;
  logic               req_we_q;

  logic any_hit;
  logic last_beat;
  logic last_fill;

  assign any_hit   = hit1_i | hit2_i;
  assign last_beat = (beat_q == BeatW'(LINE_WORDS - 1));
  assign last_fill = (state_q == StRefill) && mem_ack_i && last_beat;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      beat_q    <= '0;
      victim_q  <= 1'b0;
      req_tag_q <= '0;
      req_idx_q <= '0;
      req_we_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      victim_q <= victim_d;
      if (state_q == StIdle && req_valid_i) begin
        req_tag_q <= req_addr_i[31 -: TAG_W];
        req_idx_q <= req_addr_i[OFFSET_W +: INDEX_W];
        req_we_q  <= req_we_i;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    victim_d     = victim_q;
    busy_o       = (state_q != StIdle);
    resp_done_o  = 1'b0;
    lru_index_o  = req_idx_q;
    lru_hit1_o   = 1'b0;
    lru_hit2_o   = 1'b0;
    lru_update_o = 1'b0;
    lru_change_o = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    beat_o       = beat_q;
    fill_we_o    = 1'b0;
    tag_we_o     = 1'b0;
    dirty_set_o  = 1'b0;
    acc_way_o    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid_i) state_d = StLookup;
      end
      StLookup: begin
        if (any_hit) begin
          // Both ways matching means corrupt tags; resolve to way 0.
          lru_update_o = 1'b1;
          lru_hit1_o   = hit1_i;
          lru_hit2_o   = hit2_i & ~hit1_i;
          acc_way_o    = ~hit1_i;
          dirty_set_o  = req_we_q;
          state_d      = StDone;
        end else begin
          victim_d = way_sel_i;
          beat_d   = '0;
          state_d  = (way_sel_i ? dirty2_i : dirty1_i) ? StWb : StRefill;
        end
      end
      StWb: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        acc_way_o  = victim_q;
        mem_addr_o = {(victim_q ? tag2_i : tag1_i), req_idx_q, beat_q, 2'b00};
        if (mem_ack_i) begin
          beat_d = beat_q + BeatW'(1);
          if (last_beat) begin
            beat_d  = '0;
            state_d = StRefill;
          end
        end
      end
      StRefill: begin
        mem_req_o  = 1'b1;
        acc_way_o  = victim_q;
        mem_addr_o = {req_tag_q, req_idx_q, beat_q, 2'b00};
        if (mem_ack_i) begin
          fill_we_o = 1'b1;
          beat_d    = beat_q + BeatW'(1);
          if (last_beat) begin
            // Install the line; the repeated lookup then hits and ages the LRU.
            tag_we_o     = 1'b1;
            lru_change_o = 1'b1;
            beat_d       = '0;
            state_d      = StLookup;
          end
        end
      end
      StDone: begin
        resp_done_o = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef DCACHE_PERF_CNT_EN
  // The lookup right after a refill always hits; it is the tail of a miss.
  logic        refill_q;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      refill_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      refill_q <= last_fill;
      if (state_q == StLookup) begin
        if (any_hit && !refill_q) hit_cnt_q <= hit_cnt_q + 32'd1;
        if (!any_hit) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  // Counters are not built; last_fill only feeds them.
  logic unused_last_fill;
  assign unused_last_fill = last_fill;
`endif

endmodule
